// File: rtl/gcd_stein32.sv
// gcd_stein32: iterative binary (Stein) GCD engine with valid/ready in and out.
// One subtract-and-normalize step per cycle; trailing-zero counts are combinational.
module gcd_stein32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] gcd_o,
  output logic             busy_o
);

  localparam int unsigned TZ_W = $clog2(WIDTH + 1);
  localparam int unsigned K_W  = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_LOOP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Trailing-zero count; returns WIDTH for an all-zero input.
  function automatic logic [TZ_W-1:0] tz(input logic [WIDTH-1:0] x);
    logic [TZ_W-1:0] n;
    n = TZ_W'(WIDTH);
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (x[i]) n = TZ_W'(i);
    end
    return n;
  endfunction

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] ra, rb, ra_nx, rb_nx;
  logic [K_W-1:0]   k, k_nx;
  logic [WIDTH-1:0] gcd_nx;
  logic             in_ready_nx, out_valid_nx, busy_nx;

  logic             a_gt_b_c;
  logic [WIDTH-1:0] diff_c;
  logic [TZ_W-1:0]  tz_a_c, tz_b_c, tz_or_c, tz_d_c;

  // Shared datapath: one magnitude subtract and the trailing-zero counts it needs.
  always_comb begin
    a_gt_b_c = (ra > rb);
    diff_c   = a_gt_b_c ? (ra - rb) : (rb - ra);
    tz_a_c   = tz(ra);
    tz_b_c   = tz(rb);
    tz_or_c  = tz(ra | rb);
    tz_d_c   = tz(diff_c);
  end

  // Next-state and next-register computation.
  always_comb begin
    state_nx = state;
    ra_nx    = ra;
    rb_nx    = rb;
    k_nx     = k;
    gcd_nx   = gcd_o;
    case (state)
      S_IDLE: begin
        if (in_valid_i && in_ready_o) begin
          ra_nx    = a_i;
          rb_nx    = b_i;
          state_nx = S_INIT;
        end
      end
      S_INIT: begin
        if (ra == '0) begin
          gcd_nx   = rb;
          state_nx = S_DONE;
        end else if (rb == '0) begin
          gcd_nx   = ra;
          state_nx = S_DONE;
        end else begin
          // Both nonzero, so the common power of two is at most WIDTH-1.
          k_nx     = K_W'(tz_or_c);
          ra_nx    = ra >> tz_a_c;
          rb_nx    = rb >> tz_b_c;
          state_nx = S_LOOP;
        end
      end
      S_LOOP: begin
        if (ra == rb) begin
          gcd_nx   = ra << k;
          state_nx = S_DONE;
        end else if (a_gt_b_c) begin
          ra_nx = diff_c >> tz_d_c;
        end else begin
          rb_nx = diff_c >> tz_d_c;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    in_ready_nx  = (state_nx == S_IDLE);
    out_valid_nx = (state_nx == S_DONE);
    busy_nx      = (state_nx == S_INIT) || (state_nx == S_LOOP);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      ra          <= '0;
      rb          <= '0;
      k           <= '0;
      gcd_o       <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nx;
      ra          <= ra_nx;
      rb          <= rb_nx;
      k           <= k_nx;
      gcd_o       <= gcd_nx;
      in_ready_o  <= in_ready_nx;
      out_valid_o <= out_valid_nx;
      busy_o      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_gcd_stein32.sv
// tb_gcd_stein32: directed and random checks of gcd_stein32 against a Euclid reference.
module tb_gcd_stein32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] a_i, b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] gcd_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  gcd_stein32 #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .gcd_o      (gcd_o),
    .busy_o     (busy_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Reference: Euclid's algorithm with the modulo operator.
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction: accept, wait for result, stall, hand off.
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int stall, input bit pulse);
    logic [31:0] exp_g;
    int lat, busy_n, bad_wait, bad_stall;
    exp_g = ref_gcd(a, b);
    check_bit("idle_ready", in_ready_o, 1'b1);
    in_valid_i = 1'b1;
    a_i = a;
    b_i = b;
    tick();
    in_valid_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    lat = 0;
    busy_n = 0;
    bad_wait = 0;
    while (!out_valid_o && lat < 80) begin
      if (busy_o) busy_n++;
      if (in_ready_o) bad_wait++;
      tick();
      lat++;
    end
    check_bit("valid_timeout", out_valid_o, 1'b1);
    check_bit("latency_bound", lat <= 65, 1'b1);
    if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_n), 32'(lat));
    check("ready_while_busy", 32'(bad_wait), 32'd0);
    check_bit("busy_in_done", busy_o, 1'b0);
    check_bit("ready_in_done", in_ready_o, 1'b0);
    check("gcd", gcd_o, exp_g);
    bad_stall = 0;
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        in_valid_i = (i % 2 == 0);
        a_i = 32'd9;
        b_i = 32'd6;
      end
      tick();
      if (gcd_o !== exp_g || out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || busy_o !== 1'b0)
        bad_stall++;
    end
    in_valid_i = 1'b0;
    check("stall_hold", 32'(bad_stall), 32'd0);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check_bit("handoff_valid", out_valid_o, 1'b0);
    check_bit("handoff_ready", in_ready_o, 1'b1);
    check_bit("handoff_busy", busy_o, 1'b0);
    check("gcd_keep", gcd_o, exp_g);
  endtask

  // Directed steps followed by the random regression.
  initial begin
    logic [31:0] ra, rb;
    int sel, s, stall;
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    tick();
    tick();
    check_bit("rst_ready", in_ready_o, 1'b1);
    check_bit("rst_valid", out_valid_o, 1'b0);
    check_bit("rst_busy", busy_o, 1'b0);
    check("rst_gcd", gcd_o, 32'd0);
    rst_i = 1'b0;
    tick();

    run_pair(32'd12, 32'd18, 3, 0, 1'b0);
    run_pair(32'd0, 32'd0, 1, 0, 1'b0);
    run_pair(32'd0, 32'd40, 1, 0, 1'b0);
    run_pair(32'd40, 32'd0, 1, 0, 1'b0);
    run_pair(32'h8000_0000, 32'hC000_0000, 3, 0, 1'b0);
    run_pair(32'd7, 32'd7, 2, 0, 1'b0);
    run_pair(32'hFFFF_FFFF, 32'h0000_FFFF, -1, 5, 1'b1);

    // Reset during LOOP discards the operation.
    in_valid_i = 1'b1;
    a_i = 32'hFFFF_FFFF;
    b_i = 32'd1;
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    tick();
    check_bit("mid_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_bit("mid_rst_ready", in_ready_o, 1'b1);
    check_bit("mid_rst_valid", out_valid_o, 1'b0);
    check_bit("mid_rst_busy", busy_o, 1'b0);
    run_pair(32'd9, 32'd6, 3, 0, 1'b0);

    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) begin
        s = $urandom_range(0, 2);
        if (s != 1) ra = 32'd0;
        if (s != 0) rb = 32'd0;
      end else if (sel == 1) begin
        s = $urandom_range(16, 30);
        ra = (ra | 32'd1) << s;
        rb = (rb | 32'd1) << s;
      end else if (sel == 2) begin
        ra = 32'($urandom_range(1, 64));
        rb = 32'($urandom_range(1, 64));
      end
      stall = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      run_pair(ra, rb, -1, stall, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
